// File: rtl/adc_lvds_serializer_if.sv
// ============================================================================
// Module   : adc_lvds_serializer_if
// Brief    : Sample handshake, control and lane signals of the LVDS serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface adc_lvds_serializer_if;
  logic        TxEn;
  logic [1:0]  TestMode;
  logic [13:0] SmpData0;
  logic [13:0] SmpData1;
  logic        SmpValid;
  logic        SmpReady;
  logic        DatLine0;
  logic        DatLine1;
  logic        FrmLine;
  logic [7:0]  Underflow;

  modport master (
    output TxEn, TestMode, SmpData0, SmpData1, SmpValid,
    input  SmpReady, DatLine0, DatLine1, FrmLine, Underflow
  );

  modport slave (
    input  TxEn, TestMode, SmpData0, SmpData1, SmpValid,
    output SmpReady, DatLine0, DatLine1, FrmLine, Underflow
  );
endinterface

`default_nettype wire

// File: rtl/adc_lvds_serializer.sv
// ============================================================================
// Module   : adc_lvds_serializer
// Brief    : Two-lane 14-bit sample-pair serializer with frame line and
//            deskew/sync/ramp training patterns.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adc_lvds_serializer #(
  parameter logic [13:0] IDLE_PATTERN   = 14'h2000,
  parameter logic [13:0] DESKEW_PATTERN = 14'h2AAA,
  parameter logic [13:0] SYNC_PATTERN   = 14'h3F80
) (
  input  logic                  DatClk,
  input  logic                  DatRst,
  adc_lvds_serializer_if.slave  tx
);

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_DESKEW = 2'b01;
  localparam logic [1:0] MODE_SYNC   = 2'b10;
  localparam logic [1:0] MODE_RAMP   = 2'b11;
  localparam logic [3:0] LAST_SLOT   = 4'd13;

  logic [3:0]  cnt_q,       cnt_d;
  logic [13:0] hold_a_q,    hold_a_d;
  logic [13:0] hold_b_q,    hold_b_d;
  logic        hold_full_q, hold_full_d;
  logic [13:0] sh1_q,       sh1_d;
  logic [13:0] sh0_q,       sh0_d;
  logic        line0_q,     line0_d;
  logic        line1_q,     line1_d;
  logic        frm_q,       frm_d;
  logic        ready_q,     ready_d;
  logic [7:0]  ufl_q,       ufl_d;
  logic [13:0] ramp_q,      ramp_d;

  logic        boundary;
  logic        xfer;
  logic        drain;
  logic [13:0] word_a;
  logic [13:0] word_b;

  always_comb begin
    boundary    = (cnt_q == LAST_SLOT) && tx.TxEn;
    xfer        = tx.SmpValid && ready_q;
    drain       = 1'b0;
    word_a      = IDLE_PATTERN;
    word_b      = IDLE_PATTERN;
    ufl_d       = ufl_q;
    ramp_d      = ramp_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
    hold_full_d = hold_full_q;
    sh1_d       = sh1_q;
    sh0_d       = sh0_q;
    cnt_d       = cnt_q;

    if (boundary) begin
      case (tx.TestMode)
        MODE_NORMAL: begin
          if (hold_full_q) begin
            word_a = hold_a_q;
            word_b = hold_b_q;
            drain  = 1'b1;
          end else if (ufl_q != 8'hFF) begin
            ufl_d = ufl_q + 8'd1;
          end
        end
        MODE_DESKEW: begin
          word_a = DESKEW_PATTERN;
          word_b = DESKEW_PATTERN;
          drain  = 1'b1;
        end
        MODE_SYNC: begin
          word_a = SYNC_PATTERN;
          word_b = SYNC_PATTERN;
          drain  = 1'b1;
        end
        default: begin
          word_a = ramp_q;
          word_b = ramp_q + 14'd1;
          ramp_d = ramp_q + 14'd2;
        end
      endcase
    end

    // A transfer on the same edge refills the slot the boundary just drained.
    if (xfer) begin
      hold_a_d    = tx.SmpData0;
      hold_b_d    = tx.SmpData1;
      hold_full_d = 1'b1;
    end else if (drain) begin
      hold_full_d = 1'b0;
    end

    // Lane 1 carries bits [13:7] of A then B, lane 0 bits [6:0]; MSB leaves first.
    if (!tx.TxEn) begin
      cnt_d = LAST_SLOT;
    end else if (boundary) begin
      cnt_d = 4'd0;
      sh1_d = {word_a[13:7], word_b[13:7]};
      sh0_d = {word_a[6:0],  word_b[6:0]};
    end else begin
      cnt_d = cnt_q + 4'd1;
      sh1_d = {sh1_q[12:0], 1'b0};
      sh0_d = {sh0_q[12:0], 1'b0};
    end

    line1_d = tx.TxEn && sh1_d[13];
    line0_d = tx.TxEn && sh0_d[13];
    frm_d   = tx.TxEn && (cnt_d < 4'd7);

    // Registered ready looks one edge ahead so a refill can coincide with a load.
    ready_d = (tx.TestMode == MODE_NORMAL) &&
              (!hold_full_d || ((cnt_d == LAST_SLOT) && tx.TxEn));
  end

  always_ff @(posedge DatClk or posedge DatRst) begin
    if (DatRst) begin
      cnt_q       <= LAST_SLOT;
      hold_a_q    <= 14'd0;
      hold_b_q    <= 14'd0;
      hold_full_q <= 1'b0;
      sh1_q       <= 14'd0;
      sh0_q       <= 14'd0;
      line0_q     <= 1'b0;
      line1_q     <= 1'b0;
      frm_q       <= 1'b0;
      ready_q     <= 1'b0;
      ufl_q       <= 8'd0;
      ramp_q      <= 14'd0;
    end else begin
      cnt_q       <= cnt_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      hold_full_q <= hold_full_d;
      sh1_q       <= sh1_d;
      sh0_q       <= sh0_d;
      line0_q     <= line0_d;
      line1_q     <= line1_d;
      frm_q       <= frm_d;
      ready_q     <= ready_d;
      ufl_q       <= ufl_d;
      ramp_q      <= ramp_d;
    end
  end

  assign tx.SmpReady  = ready_q;
  assign tx.DatLine0  = line0_q;
  assign tx.DatLine1  = line1_q;
  assign tx.FrmLine   = frm_q;
  assign tx.Underflow = ufl_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_lvds_serializer.sv
// ============================================================================
// Module   : tb_adc_lvds_serializer
// Brief    : Directed self-checking bench for adc_lvds_serializer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adc_lvds_serializer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   pair_idx;
  bit   feed_en;
  logic [13:0] a;
  logic [13:0] b;

  adc_lvds_serializer_if bus ();

  adc_lvds_serializer dut (
    .DatClk (clk),
    .DatRst (rst),
    .tx     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; when feeding, a completed handshake advances to the next pair.
  task automatic tick();
    logic fire;
    fire = bus.SmpValid && bus.SmpReady;
    @(posedge clk);
    #1;
    if (fire && feed_en) begin
      pair_idx++;
      bus.SmpData0 = 14'(14'h1555 + pair_idx);
      bus.SmpData1 = 14'(14'h2AAA + pair_idx);
    end
  endtask

  // Deserializer model: entered at slot 0, leaves at slot 13 of the same word.
  task automatic rx_word(output logic [13:0] ra, output logic [13:0] rb,
                         input int chg_slot, input logic [1:0] chg_mode);
    int frm_err;
    frm_err = 0;
    ra = 14'd0;
    rb = 14'd0;
    for (int k = 0; k < 14; k++) begin
      if (k < 7) begin
        ra[13-k] = bus.DatLine1;
        ra[6-k]  = bus.DatLine0;
        if (bus.FrmLine !== 1'b1) frm_err++;
      end else begin
        rb[20-k] = bus.DatLine1;
        rb[13-k] = bus.DatLine0;
        if (bus.FrmLine !== 1'b0) frm_err++;
      end
      if (k == chg_slot) bus.TestMode = chg_mode;
      if (k < 13) tick();
    end
    check("frame", frm_err, 0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    pair_idx     = 0;
    feed_en      = 1'b0;
    rst          = 1'b1;
    bus.TxEn     = 1'b0;
    bus.TestMode = 2'b00;
    bus.SmpData0 = 14'd0;
    bus.SmpData1 = 14'd0;
    bus.SmpValid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.SmpReady, 0);
    check("rst_lines", {bus.DatLine1, bus.DatLine0, bus.FrmLine}, 0);
    check("rst_ufl", bus.Underflow, 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", bus.SmpReady, 1);

    // Single pair, accepted while disabled, sent on the first enabled edge
    bus.SmpData0 = 14'h3FFF;
    bus.SmpData1 = 14'h0000;
    bus.SmpValid = 1'b1;
    tick();
    bus.SmpValid = 1'b0;
    bus.TxEn     = 1'b1;
    check("ready_full", bus.SmpReady, 0);
    tick();
    rx_word(a, b, -1, 2'b00);
    check("single_a", a, 14'h3FFF);
    check("single_b", b, 14'h0000);
    tick();
    check("ufl_after_single", bus.Underflow, 1);

    // Back-to-back stream
    pair_idx     = 0;
    bus.SmpData0 = 14'h1555;
    bus.SmpData1 = 14'h2AAA;
    feed_en      = 1'b1;
    bus.SmpValid = 1'b1;
    rx_word(a, b, -1, 2'b00);
    check("idle_a", a, 14'h2000);
    check("idle_b", b, 14'h2000);
    for (int i = 0; i < 6; i++) begin
      tick();
      rx_word(a, b, -1, 2'b00);
      check("stream_a", a, 14'(14'h1555 + i));
      check("stream_b", b, 14'(14'h2AAA + i));
      if (i == 4) begin
        bus.SmpValid = 1'b0;
        feed_en      = 1'b0;
      end
    end
    check("ufl_stream", bus.Underflow, 1);

    // Ramp, with a deskew request issued in slot 5 of the third word
    bus.TestMode = 2'b11;
    for (int w = 0; w < 3; w++) begin
      tick();
      rx_word(a, b, (w == 2) ? 5 : -1, 2'b01);
      check("ramp_a", a, 2 * w);
      check("ramp_b", b, 2 * w + 1);
    end
    tick();
    rx_word(a, b, 13, 2'b10);
    check("deskew_a", a, 14'h2AAA);
    check("deskew_b", b, 14'h2AAA);
    check("deskew_ready", bus.SmpReady, 0);
    tick();
    rx_word(a, b, -1, 2'b00);
    check("sync_a", a, 14'h3F80);
    check("sync_b", b, 14'h3F80);
    check("sync_ready", bus.SmpReady, 0);
    check("ufl_test_modes", bus.Underflow, 1);

    // Starvation past the saturation point
    bus.TestMode = 2'b00;
    repeat (300 * 14) tick();
    check("ufl_saturate", bus.Underflow, 255);
    tick();
    rx_word(a, b, -1, 2'b00);
    check("starve_a", a, 14'h2000);
    check("ufl_hold", bus.Underflow, 255);

    // TxEn pulse low in slot 4 with a word waiting in holding
    tick();
    bus.SmpData0 = 14'h1234;
    bus.SmpData1 = 14'h0ABC;
    bus.SmpValid = 1'b1;
    tick();
    bus.SmpValid = 1'b0;
    repeat (3) tick();
    bus.TxEn = 1'b0;
    tick();
    check("txen_off_lines", {bus.DatLine1, bus.DatLine0, bus.FrmLine}, 0);
    check("txen_off_ready", bus.SmpReady, 0);
    bus.TxEn = 1'b1;
    tick();
    rx_word(a, b, -1, 2'b00);
    check("retained_a", a, 14'h1234);
    check("retained_b", b, 14'h0ABC);

    // Asynchronous reset in slot 9
    tick();
    repeat (9) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_lines", {bus.DatLine1, bus.DatLine0, bus.FrmLine}, 0);
    check("arst_ufl", bus.Underflow, 0);
    check("arst_ready", bus.SmpReady, 0);
    bus.TxEn = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_ready", bus.SmpReady, 1);
    bus.TxEn = 1'b1;
    tick();
    check("post_rst_frame", bus.FrmLine, 1);
    check("post_rst_ufl", bus.Underflow, 1);
    rx_word(a, b, -1, 2'b00);
    check("post_rst_a", a, 14'h2000);
    check("post_rst_b", b, 14'h2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
